// File: rtl/qsys_serial_slave.sv
`default_nettype none
// ============================================================================
// Module   : qsys_serial_slave
// Brief    : Serial-link endpoint. Deserialises 65-bit command frames from
//            sdo/sle, runs one local register-bus read or write, and returns
//            a 32-bit response on sdi framed by srdy.
// Revision : 1.0 - initial release
// ============================================================================
module qsys_serial_slave #(
  parameter int unsigned address_size = 8,
  parameter int unsigned bus_timeout  = 256,
  parameter logic [31:0] timeout_data = 32'hDEAD_BEEF
) (
  input  logic                    csi_MCLK_clk,
  input  logic                    rsi_MRST_reset_n,
  input  logic                    sdo,
  input  logic                    sle,
  output logic                    sdi,
  output logic                    srdy,
  output logic [address_size-1:0] reg_address,
  output logic [31:0]             reg_writedata,
  output logic                    reg_write,
  output logic                    reg_read,
  input  logic [31:0]             reg_readdata,
  input  logic                    reg_waitrequest,
  output logic                    frame_err,
  output logic                    timeout_err
);

  // Timeout counter wide enough to hold bus_timeout itself.
  localparam int unsigned TW = $clog2(bus_timeout + 1);
  localparam logic [TW-1:0] c_TO_LAST = TW'(bus_timeout - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SHIFT = 3'd1;
  localparam logic [2:0] ST_CHECK = 3'd2;
  localparam logic [2:0] ST_BUS   = 3'd3;
  localparam logic [2:0] ST_RESP  = 3'd4;
  localparam logic [2:0] ST_GAP   = 3'd5;

  logic [2:0]              state_q, state_d;
  logic [64:0]             shreg_q, shreg_d;
  logic [6:0]              cnt_q, cnt_d;     // frame bit count, then response bit count
  logic [TW-1:0]           tcnt_q, tcnt_d;
  logic [31:0]             resp_q, resp_d;
  logic                    sle_q, sle_d;
  logic                    sdi_q, sdi_d;
  logic                    srdy_q, srdy_d;
  logic [address_size-1:0] addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic                    write_q, write_d;
  logic                    read_q, read_d;
  logic                    ferr_q, ferr_d;
  logic                    terr_q, terr_d;

  logic                    w_sle_rise;
  logic                    w_load;
  logic [31:0]             w_word;

  // A frame only starts on a fresh sle rising edge, so a burst that began
  // while busy never leaks into IDLE as a new frame.
  assign w_sle_rise = sle & ~sle_q;

  // Next-state logic for the frame / bus / response sequencer.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    tcnt_d  = tcnt_q;
    resp_d  = resp_q;
    sle_d   = sle;
    sdi_d   = sdi_q;
    srdy_d  = srdy_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    read_d  = read_q;
    ferr_d  = 1'b0;
    terr_d  = 1'b0;
    w_load  = 1'b0;
    w_word  = 32'h0;

    case (state_q)
      ST_IDLE: begin
        if (w_sle_rise) begin
          shreg_d = {64'h0, sdo};
          cnt_d   = 7'd1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (sle) begin
          shreg_d = {shreg_q[63:0], sdo};
          if (cnt_q != 7'd127) cnt_d = cnt_q + 7'd1;
        end else begin
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (cnt_q == 7'd65) begin
          addr_d  = shreg_q[32 +: address_size];
          wdata_d = shreg_q[31:0];
          write_d = shreg_q[64];
          read_d  = ~shreg_q[64];
          tcnt_d  = '0;
          state_d = ST_BUS;
        end else begin
          ferr_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_BUS: begin
        if (!reg_waitrequest) begin
          w_load = 1'b1;
          w_word = read_q ? reg_readdata : 32'h0;
        end else if (tcnt_q == c_TO_LAST) begin
          w_load = 1'b1;
          w_word = timeout_data;
          terr_d = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
        // Response MSB goes out with the first srdy cycle; the rest shifts.
        if (w_load) begin
          write_d = 1'b0;
          read_d  = 1'b0;
          srdy_d  = 1'b1;
          sdi_d   = w_word[31];
          resp_d  = {w_word[30:0], 1'b0};
          cnt_d   = 7'd0;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (cnt_q == 7'd31) begin
          srdy_d  = 1'b0;
          sdi_d   = 1'b0;
          state_d = ST_GAP;
        end else begin
          sdi_d  = resp_q[31];
          resp_d = {resp_q[30:0], 1'b0};
          cnt_d  = cnt_q + 7'd1;
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // sle activity while busy is discarded but reported once per burst.
    if ((state_q != ST_IDLE) && (state_q != ST_SHIFT) && w_sle_rise) ferr_d = 1'b1;
  end

  // State and output registers; reset drops strobes and srdy immediately.
  always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
    if (!rsi_MRST_reset_n) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      tcnt_q  <= '0;
      resp_q  <= '0;
      sle_q   <= 1'b0;
      sdi_q   <= 1'b0;
      srdy_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      read_q  <= 1'b0;
      ferr_q  <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      tcnt_q  <= tcnt_d;
      resp_q  <= resp_d;
      sle_q   <= sle_d;
      sdi_q   <= sdi_d;
      srdy_q  <= srdy_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      read_q  <= read_d;
      ferr_q  <= ferr_d;
      terr_q  <= terr_d;
    end
  end

  assign sdi           = sdi_q;
  assign srdy          = srdy_q;
  assign reg_address   = addr_q;
  assign reg_writedata = wdata_q;
  assign reg_write     = write_q;
  assign reg_read      = read_q;
  assign frame_err     = ferr_q;
  assign timeout_err   = terr_q;

endmodule
`default_nettype wire

// File: tb/tb_qsys_serial_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_qsys_serial_slave
// Brief    : Randomised self-checking bench for qsys_serial_slave. A bus
//            responder and output monitor run beside a transaction-level
//            model that predicts strobe length, address, data and response.
// Revision : 1.0 - initial release
// ============================================================================
module tb_qsys_serial_slave;

  localparam int unsigned c_TO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sdo, sle;
  logic        sdi, srdy;
  logic [7:0]  reg_address;
  logic [31:0] reg_writedata;
  logic        reg_write, reg_read;
  logic [31:0] rd_value;
  logic        reg_waitrequest = 1'b0;
  logic        frame_err, timeout_err;

  int n_tests = 0;
  int n_fail  = 0;

  // Bus responder / monitor state (written only by the monitor process).
  int          n_wait = 0;
  int          bus_cyc = 0;
  int          wr_cyc = 0, rd_cyc = 0, ferr_cnt = 0, terr_cnt = 0;
  logic [7:0]  cap_addr = '0;
  logic [31:0] cap_wdata = '0;
  logic [31:0] mon_word = '0;
  int          mon_bits = 0;
  logic [31:0] resp_words [64];
  int          resp_bits  [64];
  int          resp_n = 0;
  int          rd_idx = 0;

  always #5 clk = ~clk;

  qsys_serial_slave #(
    .address_size (8),
    .bus_timeout  (c_TO),
    .timeout_data (32'hDEAD_BEEF)
  ) dut (
    .csi_MCLK_clk     (clk),
    .rsi_MRST_reset_n (rst_n),
    .sdo              (sdo),
    .sle              (sle),
    .sdi              (sdi),
    .srdy             (srdy),
    .reg_address      (reg_address),
    .reg_writedata    (reg_writedata),
    .reg_write        (reg_write),
    .reg_read         (reg_read),
    .reg_readdata     (rd_value),
    .reg_waitrequest  (reg_waitrequest),
    .frame_err        (frame_err),
    .timeout_err      (timeout_err)
  );

  // Sample on the falling edge: count strobes and pulses, stall the bus for
  // n_wait cycles, and assemble each srdy burst into a response word.
  always @(negedge clk) begin
    if (reg_write) wr_cyc <= wr_cyc + 1;
    if (reg_read)  rd_cyc <= rd_cyc + 1;
    if (frame_err)   ferr_cnt <= ferr_cnt + 1;
    if (timeout_err) terr_cnt <= terr_cnt + 1;
    if (reg_read || reg_write) begin
      if (bus_cyc == 0) begin
        cap_addr  <= reg_address;
        cap_wdata <= reg_writedata;
      end
      bus_cyc         <= bus_cyc + 1;
      reg_waitrequest <= (bus_cyc + 1 <= n_wait);
    end else begin
      bus_cyc         <= 0;
      reg_waitrequest <= 1'b0;
    end
    if (srdy) begin
      mon_word <= {mon_word[30:0], sdi};
      mon_bits <= mon_bits + 1;
    end else if (mon_bits != 0) begin
      resp_words[resp_n % 64] <= mon_word;
      resp_bits[resp_n % 64]  <= mon_bits;
      resp_n   <= resp_n + 1;
      mon_bits <= 0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive nbits of a frame MSB first; bits past 65 are random filler.
  task automatic send_frame(input logic [64:0] f, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      sle = 1'b1;
      sdo = (i < 65) ? f[64-i] : 1'($urandom);
      tick();
    end
    sle = 1'b0;
    sdo = 1'b0;
    tick();
  endtask

  // One full command: model predicts strobe length, fields and response.
  task automatic run_txn(input logic rw, input logic [31:0] addr, input logic [31:0] data,
                         input int waits, input logic [31:0] rdata, input bit inject);
    int b_wr, b_rd, b_fe, b_te, k, exp_cyc;
    bit timed_out;
    logic [31:0] exp_resp;
    n_wait   = waits;
    rd_value = rdata;
    b_wr = wr_cyc; b_rd = rd_cyc; b_fe = ferr_cnt; b_te = terr_cnt;
    send_frame({rw, addr, rw ? data : 32'h0}, 65);
    if (inject) begin
      k = 0;
      while (mon_bits < 5 && k < 400) begin tick(); k++; end
      for (int i = 0; i < 8; i++) begin
        sle = 1'b1;
        sdo = 1'($urandom);
        tick();
      end
      sle = 1'b0;
    end
    k = 0;
    while (resp_n == rd_idx && k < 400) begin tick(); k++; end
    repeat (3) tick();
    timed_out = (waits >= int'(c_TO));
    exp_cyc   = timed_out ? int'(c_TO) : waits + 1;
    exp_resp  = timed_out ? 32'hDEAD_BEEF : (rw ? 32'h0 : rdata);
    chk("resp_seen", 64'(resp_n > rd_idx), 64'd1);
    chk("resp_word", 64'(resp_words[rd_idx % 64]), 64'(exp_resp));
    chk("resp_bits", 64'(resp_bits[rd_idx % 64]), 64'd32);
    chk("wr_cycles", 64'(wr_cyc - b_wr), 64'(rw ? exp_cyc : 0));
    chk("rd_cycles", 64'(rd_cyc - b_rd), 64'(rw ? 0 : exp_cyc));
    chk("address",   64'(cap_addr), 64'(addr[7:0]));
    if (rw) chk("writedata", 64'(cap_wdata), 64'(data));
    chk("timeout_err", 64'(terr_cnt - b_te), 64'(timed_out ? 1 : 0));
    chk("frame_err",   64'(ferr_cnt - b_fe), 64'(inject ? 1 : 0));
    rd_idx = resp_n;
  endtask

  initial begin
    int b_wr, b_rd, b_fe, k;
    logic [64:0] f;
    rst_n = 1'b0; sle = 1'b0; sdo = 1'b0; rd_value = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sdi",   64'(sdi), 64'd0);
    chk("rst_srdy",  64'(srdy), 64'd0);
    chk("rst_wr",    64'(reg_write), 64'd0);
    chk("rst_rd",    64'(reg_read), 64'd0);
    chk("rst_addr",  64'(reg_address), 64'd0);
    chk("rst_wdata", 64'(reg_writedata), 64'd0);
    chk("rst_ferr",  64'(frame_err), 64'd0);
    chk("rst_terr",  64'(timeout_err), 64'd0);
    rst_n = 1'b1;
    repeat (3) tick();

    // Directed: write, stalled read, timeout.
    run_txn(1'b1, 32'h0000_0012, 32'hA5A5_0F0F, 0, $urandom, 1'b0);
    run_txn(1'b0, 32'h0000_0034, 32'h0, 3, 32'h1234_5678, 1'b0);
    run_txn(1'b0, 32'h0000_0056, 32'h0, 1000, 32'h0BAD_F00D, 1'b0);

    // Malformed lengths: short, one short of 65, overlong.
    b_wr = wr_cyc; b_rd = rd_cyc; b_fe = ferr_cnt;
    f = {1'b0, 32'($urandom), 32'($urandom)};
    send_frame(f, 40);  repeat (4) tick();
    send_frame(f, 64);  repeat (4) tick();
    send_frame(f, 66);  repeat (40) tick();
    chk("malformed_ferr", 64'(ferr_cnt - b_fe), 64'd3);
    chk("malformed_wr",   64'(wr_cyc - b_wr), 64'd0);
    chk("malformed_rd",   64'(rd_cyc - b_rd), 64'd0);
    chk("malformed_resp", 64'(resp_n - rd_idx), 64'd0);

    // Reset in the middle of a frame.
    f = {1'b1, 32'h0000_0055, 32'h1111_2222};
    for (int i = 0; i < 30; i++) begin
      sle = 1'b1; sdo = f[64-i]; tick();
    end
    sle = 1'b1; sdo = f[34];
    #2 rst_n = 1'b0;
    #1;
    chk("midframe_srdy", 64'(srdy), 64'd0);
    chk("midframe_wr",   64'(reg_write), 64'd0);
    chk("midframe_rd",   64'(reg_read), 64'd0);
    sle = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();

    // Reset during the response.
    n_wait = 0; rd_value = 32'hFFFF_FFFF;
    send_frame({1'b0, 32'h0000_0077, 32'h0}, 65);
    k = 0;
    while (mon_bits < 10 && k < 400) begin tick(); k++; end
    #2 rst_n = 1'b0;
    #1;
    chk("resp_rst_srdy", 64'(srdy), 64'd0);
    chk("resp_rst_sdi",  64'(sdi), 64'd0);
    chk("resp_rst_addr", 64'(reg_address), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    rd_idx = resp_n;
    b_wr = wr_cyc; b_rd = rd_cyc;
    repeat (60) tick();
    chk("post_rst_resp", 64'(resp_n - rd_idx), 64'd0);
    chk("post_rst_bus",  64'((wr_cyc - b_wr) + (rd_cyc - b_rd)), 64'd0);
    run_txn(1'b1, 32'hCAFE_0099, 32'h0F1E_2D3C, 0, $urandom, 1'b0);

    // sle burst while the response is being shifted out.
    run_txn(1'b0, 32'h0000_00AB, 32'h0, 0, 32'h8421_C3A5, 1'b1);

    // Randomised transactions.
    for (int t = 0; t < 16; t++) begin
      run_txn(1'($urandom), 32'($urandom), 32'($urandom),
              int'($urandom_range(0, 20)), 32'($urandom), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/qsys_serial_slave.md
Name: qsys_serial_slave

Overview:
- Serial endpoint on the far side of the device serial link.
- Deserialises command frames on sdo/sle and executes each one as a single read or write on a local register bus (Avalon-MM master style).
- Serialises a 32-bit response back on sdi, framed by srdy.
- Shares the link clock, so no CDC is involved.

Parameters:
- address_size, 8: width of reg_address; frame address bits above this width are dropped.
- bus_timeout, 256: maximum cycles to wait on reg_waitrequest before the access is aborted.
- timeout_data, 32'hDEAD_BEEF: response word returned on a bus timeout.

Ports:
- csi_MCLK_clk  in  1  clock; shared with the link master.
- rsi_MRST_reset_n  in  1  asynchronous active-low reset.
- sdo  in  1  serial command data from the link master, MSB first.
- sle  in  1  command frame enable; one bit per clock while high.
- sdi  out  1  serial response data, MSB first.
- srdy  out  1  response frame enable.
- reg_address  out  address_size  local bus address.
- reg_writedata  out  32  local bus write data.
- reg_write  out  1  local write strobe.
- reg_read  out  1  local read strobe.
- reg_readdata  in  32  local read data; valid in the cycle reg_waitrequest is low.
- reg_waitrequest  in  1  local bus stall.
- frame_err  out  1  one-cycle pulse: malformed frame discarded.
- timeout_err  out  1  one-cycle pulse: local access timed out.

Behaviour:
- One clock domain; reset is asynchronous and active-low, all flops.
- Reset values: sdi=0, srdy=0, reg_write=0, reg_read=0, reg_address=0, reg_writedata=0, frame_err=0, timeout_err=0, state=IDLE, shift register and counters cleared.
- Frame format: 65 bits. Bit 64 = R/W (1 = write), bits 63:32 = address, bits 31:0 = write data (zero for reads).
- Sampling: sdo is sampled on every rising clock where sle=1.

State machine:
- IDLE: wait for sle=1. The first sle=1 cycle captures bit 64, clears and advances the bit counter, then goes to SHIFT.
- SHIFT: shift sdo in while sle=1 and increment the bit counter (7 bits, saturating at 127).
  - On the first sle=0 cycle, go to CHECK.
- CHECK (1 cycle):
  - Count == 65: latch reg_address = frame[32+address_size-1:32] and reg_writedata = frame[31:0], then go to BUS.
  - Otherwise: pulse frame_err and go to IDLE. No bus access and no response.
- BUS:
  - Hold reg_write or reg_read high, per R/W, from the first BUS cycle.
  - Completion is the first cycle with reg_waitrequest=0. Deassert the strobe on the next cycle.
  - Read: capture reg_readdata at completion.
  - Write: response word = 32'h0000_0000.
  - Timeout: count strobe cycles with waitrequest=1. When the count reaches bus_timeout, drop the strobe, pulse timeout_err, set response = timeout_data and go to RESP.
  - Minimum BUS occupancy is 1 cycle (waitrequest already low).
- RESP: srdy=1 for exactly 32 consecutive cycles. sdi carries response[31] in the first srdy cycle, down to response[0] in the last. Both outputs are registered.
- GAP: srdy=0 for 1 cycle, then go to IDLE.

Boundary conditions:
- sle=1 outside IDLE/SHIFT (during CHECK, BUS, RESP or GAP) is ignored. Ignored bits do not start a frame, and frame_err pulses once per such sle rising edge.
- sle must be seen low in IDLE before a new frame starts; a frame cannot start in the same cycle as GAP.
- Frames longer than 65 bits saturate the counter and are rejected in CHECK.
- Reset asserted mid-frame or mid-access drops the strobes and srdy immediately (asynchronously); no response is sent after release.
- reg_readdata is ignored on writes.

Test Plan:
- Write: 65-bit frame with R/W=1, addr=0x12, data=0xA5A5_0F0F, waitrequest=0 -> one-cycle reg_write with reg_address=0x12 and reg_writedata=0xA5A5_0F0F; then srdy high for 32 cycles with sdi all 0, then srdy low.
- Read: frame with R/W=0, addr=0x34; readdata=0x1234_5678 with waitrequest held 3 cycles -> reg_read high for 4 cycles; sdi shifts out 0x1234_5678 MSB first over 32 srdy cycles.
- Timeout: bus_timeout=16, waitrequest stuck at 1 on a read -> reg_read drops after 16 cycles, timeout_err pulses once, response 0xDEAD_BEEF.
- Malformed: 40-bit sle burst, then a 66-bit sle burst -> frame_err pulses after each; reg_read and reg_write never assert; srdy stays 0.
- Reset: rsi_MRST_reset_n pulsed low at bit 30 of a frame, then low again in RESP cycle 10 -> all outputs return to reset values at once; a following valid write frame executes normally.
- Busy: sle burst during RESP -> ignored, frame_err pulses once, and the in-progress response completes unchanged.
